// File: rtl/uart_baud_gen_prog.sv
// uart_baud_gen_prog: programmable UART oversample/bit tick generator with shadowed divisor.
// Define UART_BAUDGEN_FRAC_EN to add the DivFrac sixteenths accumulator.
module uart_baud_gen_prog #(
  parameter int DIV_WIDTH = 16,
  parameter int OVERSAMPLE = 16,
  parameter int RESET_DIV = 27
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          Enable,
  input  logic                          DivLoad,
  input  logic [DIV_WIDTH-1:0]          DivValue,
  input  logic [3:0]                    DivFrac,
  output logic                          DivPending,
  output logic                          Tick16,
  output logic                          TickBaud,
  output logic                          BaudClock,
  output logic [$clog2(OVERSAMPLE)-1:0] Phase
);
  localparam int PW = $clog2(OVERSAMPLE);
  localparam logic [DIV_WIDTH-1:0] RST_DIV = DIV_WIDTH'(RESET_DIV);
  localparam logic [DIV_WIDTH-1:0] RST_CNT = DIV_WIDTH'(RESET_DIV == 0 ? 0 : RESET_DIV - 1);
  logic [DIV_WIDTH-1:0] div, shadow, cnt, nextDiv, effDiv;
  logic reload, apply, carry;
  assign reload = Enable && cnt == '0;
  assign apply = DivPending && (reload || !Enable);
  // the divisor taking effect this cycle; a zero divisor behaves as one
  assign nextDiv = apply ? shadow : div;
  assign effDiv = nextDiv == '0 ? DIV_WIDTH'(1) : nextDiv;
`ifdef UART_BAUDGEN_FRAC_EN
  logic [3:0] frac, shadowFrac, acc;
  logic [4:0] accSum;
  assign accSum = {1'b0, acc} + {1'b0, apply ? shadowFrac : frac};
  assign carry = accSum[4];
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      frac <= '0;
      shadowFrac <= '0;
      acc <= '0;
    end else begin
      if (DivLoad) shadowFrac <= DivFrac;
      if (apply) frac <= shadowFrac;
      if (reload) acc <= accSum[3:0];
    end
`else
  logic unusedFrac;
  assign unusedFrac = ^DivFrac;
  assign carry = 1'b0;
`endif
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      div <= RST_DIV;
      shadow <= RST_DIV;
      cnt <= RST_CNT;
      Phase <= '0;
      DivPending <= 1'b0;
      Tick16 <= 1'b0;
      TickBaud <= 1'b0;
    end else begin
      if (DivLoad) shadow <= DivValue;
      if (apply) div <= shadow;
      DivPending <= DivLoad || (DivPending && !apply);
      // a fractional carry stretches this period by one cycle
      cnt <= (!Enable || reload) ? ((carry && reload) ? effDiv : effDiv - 1'b1) : cnt - 1'b1;
      Tick16 <= reload;
      TickBaud <= reload && Phase == PW'(OVERSAMPLE - 1);
      Phase <= !Enable ? '0 : Phase + PW'(reload);
    end
  assign BaudClock = Phase[PW-1];
endmodule

// File: tb/tb_uart_baud_gen_prog.sv
// tb_uart_baud_gen_prog: scoreboard bench; an absolute-time tick schedule model predicts every cycle.
module tb_uart_baud_gen_prog;
  localparam int DW = 16, OS = 16, RD = 27, PW = $clog2(OS);
`ifdef UART_BAUDGEN_FRAC_EN
  localparam bit FracOn = 1'b1;
`else
  localparam bit FracOn = 1'b0;
`endif
  logic Clock = 1'b0;
  logic Reset, Enable, DivLoad, DivPending, Tick16, TickBaud, BaudClock;
  logic [DW-1:0] DivValue;
  logic [3:0] DivFrac;
  logic [PW-1:0] Phase;
  typedef struct { logic t16, tb, bc, pend; int ph; } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  int n = 0, div = RD, shadow = RD, fracA = 0, shadowFrac = 0, acc = 0, nextTick = RD, ticks = 0;
  bit pend = 1'b0;

  uart_baud_gen_prog #(.DIV_WIDTH(DW), .OVERSAMPLE(OS), .RESET_DIV(RD)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .DivLoad(DivLoad), .DivValue(DivValue),
    .DivFrac(DivFrac), .DivPending(DivPending), .Tick16(Tick16), .TickBaud(TickBaud),
    .BaudClock(BaudClock), .Phase(Phase));

  always #5 Clock = ~Clock;

  function automatic int eff(input int d);
    return d == 0 ? 1 : d;
  endfunction

  // Model: the next tick is an absolute edge number; ticks since enable give the phase.
  task automatic step();
    exp_t e;
    bit tick, app;
    int per;
    n++;
    tick = 1'b0;
    if (Reset) begin
      div = RD; shadow = RD; fracA = 0; shadowFrac = 0; acc = 0;
      pend = 1'b0; ticks = 0; nextTick = n + eff(RD);
    end else begin
      tick = Enable && n == nextTick;
      app = pend && (tick || !Enable);
      if (app) begin div = shadow; fracA = shadowFrac; end
      pend = DivLoad || (pend && !app);
      if (DivLoad) begin shadow = int'(DivValue); shadowFrac = int'(DivFrac); end
      if (!Enable) begin
        ticks = 0;
        nextTick = n + eff(div);
      end else if (tick) begin
        ticks++;
        acc += fracA;
        per = eff(div) + ((FracOn && acc >= 16) ? 1 : 0);
        acc %= 16;
        nextTick = n + per;
      end
    end
    e.t16 = tick;
    e.ph = ticks % OS;
    e.tb = tick && e.ph == 0;
    e.bc = e.ph >= OS / 2;
    e.pend = pend;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s edge %0d: got %0d expected %0d", name, n, act, req);
    end
  endtask

  always @(negedge Clock) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("Tick16", 32'(Tick16), 32'(e.t16));
      chk("TickBaud", 32'(TickBaud), 32'(e.tb));
      chk("BaudClock", 32'(BaudClock), 32'(e.bc));
      chk("DivPending", 32'(DivPending), 32'(e.pend));
      chk("Phase", 32'(Phase), e.ph);
    end
  end

  task automatic cyc(input bit rst, input bit en, input bit ld, input int val, input int fr);
    @(negedge Clock);
    #1;
    Reset = rst; Enable = en; DivLoad = ld; DivValue = DW'(val); DivFrac = 4'(fr);
    @(posedge Clock);
    step();
  endtask

  initial begin
    Reset = 1'b1; Enable = 1'b0; DivLoad = 1'b0; DivValue = '0; DivFrac = '0;
    repeat (3) cyc(1, 0, 0, 0, 0);
    repeat (910) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 5, 0);
    repeat (60) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 27, 0);
    repeat (8) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 8, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 3, 0);
    repeat (60) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    repeat (40) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 0);
    repeat (40) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 10, 8);
    repeat (200) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 9, 0);
    repeat (45) cyc(0, 1, 0, 0, 0);
    repeat (10) cyc(0, 0, 0, 0, 0);
    repeat (40) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 4, 0);
    repeat (2) cyc(1, 1, 0, 0, 0);
    repeat (60) cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 999) == 0, $urandom_range(0, 19) != 0, $urandom_range(0, 29) == 0,
          $urandom_range(0, 6), $urandom_range(0, 15));
    repeat (2) @(negedge Clock);
    #1;
    chk("drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
